ddr_channel_arb_n: RTL
======================

Name: ddr_channel_arb_n

Overview:
- N-channel successor to the two-port icache/dcache DDR arbiter.
- Arbitrates NUM_CH request channels (icache, dcache, future prefetcher/PTW) onto the single DDR port.
- Provides selectable round-robin or fixed priority, a per-request burst flag, and a per-channel flush that cancels an in-flight response.
- Sits between the caches and the DDR interface at core top level.

Parameters:
NUM_CH, 2, number of request channels (>=2)
ADDR_W, 64, request/DDR index width
DATA_W, 512, cacheline data width
RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (channel 0 highest)

Ports:
clock  in  1  core clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  per-channel accept pulse
req_index  in  NUM_CH*ADDR_W  per-channel address; channel i at bits [i*ADDR_W +: ADDR_W]
req_write  in  NUM_CH  1 = write, 0 = read
req_burst  in  NUM_CH  burst-mode request
req_wdata  in  NUM_CH*DATA_W  per-channel write line
req_flush  in  NUM_CH  cancel outstanding response for channel
resp_done  out  NUM_CH  one-cycle completion pulse
resp_data  out  DATA_W  read data, valid while any resp_done bit is high
ddr_chip_enable  out  1  one-cycle DDR command strobe
ddr_index  out  ADDR_W  DDR address
ddr_write_enable  out  1  DDR write
ddr_burst_mode  out  1  DDR burst
ddr_write_data  out  DATA_W  DDR write line
ddr_read_data  in  DATA_W  DDR read line
ddr_operation_done  in  1  DDR completion pulse
ddr_ready  in  1  DDR can accept a command

Behaviour:
- Reset (synchronous, highest priority over all events): state = IDLE, rr_ptr = 0, cancel = 0, grant = 0. All outputs are 0.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Transition when |req_valid && ddr_ready. Select the winner, latch index/write/burst/wdata/grant, pulse req_ready[grant] for this cycle only, then go to ISSUE.
  - req_ready is combinational from req_valid and ddr_ready in IDLE only. Elsewhere it is 0.
- Winner selection:
  - RR_MODE=1: first valid channel at or after rr_ptr, searched cyclically with modulo NUM_CH wrap.
  - RR_MODE=0: lowest-index valid channel.
- ISSUE:
  - ddr_chip_enable = 1 for exactly one cycle. ddr_index/write_enable/burst_mode/write_data are driven from the latched fields.
  - Go to WAIT.
  - DDR outputs hold their latched values through WAIT. ddr_chip_enable is 0 outside ISSUE.
- WAIT:
  - On ddr_operation_done, capture ddr_read_data into the resp_data register.
  - If cancel is set, go to IDLE. Otherwise go to RESP.
  - ddr_operation_done outside WAIT is ignored.
- RESP:
  - resp_done[grant] = 1 for one cycle with resp_data.
  - Writes also pulse resp_done; resp_data content is don't-care for writes.
  - Go to IDLE.
- rr_ptr update: on leaving WAIT, rr_ptr = (grant == NUM_CH-1) ? 0 : grant+1. This happens whether or not the request was cancelled.
- Flush:
  - req_flush[grant] asserted in ISSUE or WAIT sets cancel. The DDR transaction still completes; only resp_done is suppressed.
  - Flush of a non-granted channel has no effect on the current transaction.
  - Flush and done in the same WAIT cycle counts as cancelled.
  - Flush in RESP has no effect; the pulse is still delivered.
  - cancel clears on entry to IDLE.
- req_flush in IDLE blocks a request from that channel in the same cycle: the channel is treated as not valid.
- Latency: request accepted at cycle T, then ddr_chip_enable at T+1, then resp_done one cycle after ddr_operation_done.
- Minimum gap between back-to-back grants is 1 idle cycle (the RESP-to-IDLE transition).
- Only one transaction is in flight at a time.
- A requester holds req_valid and its payload until its req_ready pulse.
- Grant index width is $clog2(NUM_CH).

Test Plan:
1. Reset mid-WAIT, then release with no requests: all outputs 0, state IDLE. A subsequent request on channel 1 is granted with ce at accept+1.
2. Single read, NUM_CH=2, ch0 index 0x8000_0040, DDR done 5 cycles after ce with data 0xA5.. → resp_done[0] is 1 one cycle after done; resp_data=0xA5..; ddr_write_enable=0.
3. RR_MODE=1, NUM_CH=4, all four channels valid continuously → grant order 0,1,2,3,0. Each channel's req_ready pulses exactly once per round.
4. RR_MODE=0, ch1 and ch3 valid continuously → ch1 always wins; ch3 is never granted while ch1 is valid.
5. ch2 write with burst, req_flush[2] asserted 2 cycles after ce → ddr_write_enable=1 and ddr_burst_mode=1 held through WAIT. After done, no resp_done pulse, FSM returns to IDLE, and rr_ptr=3.
6. ddr_ready=0 while ch0 valid → no req_ready and no ce. When ddr_ready rises to 1, req_ready[0] pulses the same cycle and ce follows next cycle. A spurious ddr_operation_done in IDLE is ignored.

Source files
------------

// File: rtl/ddr_channel_arb_n.sv
`default_nettype none
// ============================================================================
// Module   : ddr_channel_arb_n
// Purpose  : Arbitrates NUM_CH cache/prefetch request channels onto a single
//            DDR port. One transaction in flight at a time. Arbitration is
//            round-robin or fixed priority (channel 0 highest). A per-channel
//            flush suppresses the completion pulse of the granted request,
//            while the DDR operation itself still runs to completion.
// Ports    : clock/reset          - core clock, synchronous active-high reset
//            req_*                - per-channel request bundle (valid, index,
//                                   write, burst, wdata, flush) and the
//                                   req_ready accept pulse
//            resp_done/resp_data  - per-channel completion pulse, read line
//            ddr_*                - single-command DDR interface
// Revision : 1.0 - initial N-channel release
// ============================================================================
module ddr_channel_arb_n #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int RR_MODE = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] req_index,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH-1:0]        req_burst,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  input  logic [NUM_CH-1:0]        req_flush,
  output logic [NUM_CH-1:0]        resp_done,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     ddr_chip_enable,
  output logic [ADDR_W-1:0]        ddr_index,
  output logic                     ddr_write_enable,
  output logic                     ddr_burst_mode,
  output logic [DATA_W-1:0]        ddr_write_data,
  input  logic [DATA_W-1:0]        ddr_read_data,
  input  logic                     ddr_operation_done,
  input  logic                     ddr_ready
);

  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [NUM_CH-1:0] CH_ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [GW-1:0]       rr_ptr;
  logic [GW-1:0]       grant;
  logic                cancel;
  logic [ADDR_W-1:0]   lat_index;
  logic                lat_write;
  logic                lat_burst;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   resp_q;

  // A channel flushing in IDLE is treated as not requesting this cycle.
  logic [NUM_CH-1:0]   eligible;
  logic [GW-1:0]       win;
  logic                win_found;
  logic [GW-1:0]       cand;
  int                  cand_i;
  logic [ADDR_W-1:0]   sel_index;
  logic [DATA_W-1:0]   sel_wdata;
  logic                flush_hit;

  assign eligible  = req_valid & ~req_flush;
  assign flush_hit = req_flush[grant];

  // Winner search: cyclic from rr_ptr in round-robin mode, from 0 otherwise.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    cand_i    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_i = (RR_MODE != 0) ? ((int'(rr_ptr) + k) % NUM_CH) : k;
      cand   = cand_i[GW-1:0];
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  // Payload mux for the winning channel.
  always_comb begin
    sel_index = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win == GW'(i)) begin
        sel_index = req_index[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    req_ready       = '0;
    resp_done       = '0;
    ddr_chip_enable = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_found && ddr_ready) begin
          req_ready = CH_ONE << win;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ddr_chip_enable = 1'b1;
        state_nxt       = ST_WAIT;
      end
      ST_WAIT: begin
        // A flush arriving together with done still counts as cancelled.
        if (ddr_operation_done) begin
          state_nxt = (cancel || flush_hit) ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: begin
        resp_done = CH_ONE << grant;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr    <= '0;
      grant     <= '0;
      cancel    <= 1'b0;
      lat_index <= '0;
      lat_write <= 1'b0;
      lat_burst <= 1'b0;
      lat_wdata <= '0;
      resp_q    <= '0;
    end else begin
      if (state == ST_IDLE && state_nxt == ST_ISSUE) begin
        grant     <= win;
        lat_index <= sel_index;
        lat_write <= req_write[win];
        lat_burst <= req_burst[win];
        lat_wdata <= sel_wdata;
      end

      if (state_nxt == ST_IDLE) begin
        cancel <= 1'b0;
      end else if ((state == ST_ISSUE || state == ST_WAIT) && flush_hit) begin
        cancel <= 1'b1;
      end

      // The pointer advances past the granted channel even when cancelled.
      if (state == ST_WAIT && ddr_operation_done) begin
        resp_q <= ddr_read_data;
        rr_ptr <= (grant == GW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  // DDR command fields stay on the latched values through WAIT.
  assign ddr_index        = lat_index;
  assign ddr_write_enable = lat_write;
  assign ddr_burst_mode   = lat_burst;
  assign ddr_write_data   = lat_wdata;
  assign resp_data        = resp_q;

endmodule
`default_nettype wire
